// File: rtl/yedge_driver_pkg.sv
// Shared dual-rail encodings and FSM state type for the top-edge driver of a
// Morphle Logic yellow-cell array.
package yedge_driver_pkg;

  localparam logic [1:0] Vempty = 2'b00;
  localparam logic [1:0] V0     = 2'b01;
  localparam logic [1:0] V1     = 2'b10;
  localparam logic [1:0] Vill   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCapture,
    StRelease
  } state_e;

  function automatic logic [1:0] encode_bit(input logic b);
    return b ? V1 : V0;
  endfunction

endpackage

// File: rtl/yedge_sync.sv
// Multi-stage synchronizer for asynchronous back-channel bits, plus a flag that
// is set when two consecutive synchronized samples are identical.
module yedge_sync #(
  parameter int unsigned Width  = 2,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic             stable_o
);

  logic [Width-1:0] sync_q [Stages];
  logic [Width-1:0] prev_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned s = 0; s < Stages; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned s = 1; s < Stages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o = sync_q[Stages-1];
  // Rails of one pair may skew; only trust a value seen twice in a row.
  assign stable_o = (sync_q[Stages-1] == prev_q);

endmodule

// File: rtl/yedge_driver.sv
// Clocked "red cell" column driver: injects a word as dual-rail pairs into the
// top edge of the array, collects the results, then returns to empty (4-phase).
module yedge_driver
  import yedge_driver_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TMO_W       = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_valid,
  output logic           tx_ready,
  input  logic [N-1:0]   tx_data,
  output logic           rx_valid,
  output logic [N-1:0]   rx_data,
  output logic           rx_err,
  output logic [N-1:0]   arr_uempty,
  output logic [2*N-1:0] arr_uin,
  input  logic [2*N-1:0] arr_uout
);

  state_e state_q, state_d;
  logic [2*N-1:0] uin_q, uin_d;
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic err_q, err_d;
  logic rx_valid_q, rx_valid_d;
  logic [N-1:0] rx_data_q, rx_data_d;
  logic rx_err_q, rx_err_d;

  logic [2*N-1:0] s_uout;
  logic s_stable;
  logic all_full, all_empty, any_ill;
  logic [N-1:0] s_hi;
  logic [1:0] pair;
  logic wdog_max;

  yedge_sync #(
    .Width (2*N),
    .Stages(SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (arr_uout),
    .q_o     (s_uout),
    .stable_o(s_stable)
  );

  always_comb begin
    all_full  = 1'b1;
    all_empty = 1'b1;
    any_ill   = 1'b0;
    s_hi      = '0;
    pair      = Vempty;
    for (int unsigned i = 0; i < N; i++) begin
      pair = s_uout[2*i +: 2];
      if (pair == Vempty) all_full  = 1'b0;
      else                all_empty = 1'b0;
      if (pair == Vill)   any_ill   = 1'b1;
      s_hi[i] = pair[1];
    end
  end

  assign wdog_max = &wdog_q;
  // Never accept while the array still reports anything on its back pairs.
  assign tx_ready = (state_q == StIdle) && s_stable && all_empty;

  always_comb begin
    state_d    = state_q;
    uin_d      = uin_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;

    unique case (state_q)
      StIdle: begin
        if (tx_valid && tx_ready) begin
          for (int unsigned i = 0; i < N; i++) begin
            uin_d[2*i +: 2] = encode_bit(tx_data[i]);
          end
          wdog_d  = '0;
          err_d   = 1'b0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        wdog_d = wdog_q + 1'b1;
        if (s_stable && any_ill) err_d = 1'b1;
        if (s_stable && all_full) begin
          rx_valid_d = 1'b1;
          rx_data_d  = s_hi;
          rx_err_d   = err_q | any_ill;
          state_d    = StCapture;
        end else if (wdog_max) begin
          rx_valid_d = 1'b1;
          rx_data_d  = s_hi;
          rx_err_d   = 1'b1;
          err_d      = 1'b1;
          state_d    = StCapture;
        end
      end
      StCapture: begin
        uin_d   = '0;
        wdog_d  = '0;
        state_d = StRelease;
      end
      StRelease: begin
        wdog_d = wdog_q + 1'b1;
        if (s_stable && all_empty) begin
          wdog_d  = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end else if (wdog_max) begin
          // Drain timeout: report with a second, data-less error pulse.
          wdog_d     = '0;
          err_d      = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = '0;
          rx_err_d   = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      uin_q      <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      uin_q      <= uin_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign arr_uin    = uin_q;
  assign arr_uempty = '0;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign rx_err     = rx_err_q;

endmodule
